// File: rtl/csd_mult_seq_if.sv
// ----------------------------------------------------------------------------
// csd_mult_seq_if
//   Operand / result handshake bundle for the sequential CSD multiplier.
//   The producer and consumer side sit on the master modport and the
//   multiplier sits on the slave modport.
//
//   Signals
//     in_valid   producer -> mult   operands valid
//     in_ready   mult -> producer   multiplier can take operands
//     x          producer -> mult   multiplicand, unsigned
//     multi      producer -> mult   multiplier, unsigned, recoded to CSD
//     out_valid  mult -> consumer   y / nz_digits valid
//     out_ready  consumer -> mult   consumer takes the result
//     y          mult -> consumer   (x*multi) mod 2^WIDTH
//     nz_digits  mult -> consumer   number of nonzero CSD digits of multi
// ----------------------------------------------------------------------------
interface csd_mult_seq_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] multi;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [CW-1:0]    nz_digits;

    modport master (
        output in_valid, x, multi, out_ready,
        input  in_ready, out_valid, y, nz_digits
    );

    modport slave (
        input  in_valid, x, multi, out_ready,
        output in_ready, out_valid, y, nz_digits
    );
endinterface

// File: rtl/csd_mult_seq.sv
// ----------------------------------------------------------------------------
// csd_mult_seq
//   Sequential shift-add multiplier. The multiplier operand is recoded into
//   canonical signed digits (+1/0/-1) one digit per clock, and for each
//   nonzero digit x<<k is added to or subtracted from a WIDTH-bit
//   accumulator. One multiply is in flight at a time.
//
//   Ports
//     clk   in   single clock, all state on the rising edge
//     rst   in   synchronous, active-high reset
//     bus   slave side of csd_mult_seq_if:
//             in_valid/in_ready/x/multi      operand handshake
//             out_valid/out_ready/y/nz_digits result handshake
//
//   Timing: operands accepted in IDLE, WIDTH+1 RUN cycles (digits 0..WIDTH),
//   result held in DONE until out_ready.
// ----------------------------------------------------------------------------
module csd_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    csd_mult_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   x_q,         x_d;
    // Two extra zero bits above the operand so digit k can always look at
    // m[k+1], including the final digit k = WIDTH.
    logic [WIDTH+1:0]   m_q,         m_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [CW-1:0]      k_q,         k_d;
    logic               carry_q,     carry_d;
    logic [CW-1:0]      nzcnt_q,     nzcnt_d;
    logic [WIDTH-1:0]   y_q,         y_d;
    logic [CW-1:0]      nz_q,        nz_d;
    logic               out_valid_q, out_valid_d;

    // Recoding of the current digit
    logic               mk, mk1;
    logic [1:0]         b;
    logic               dig_nz, dig_neg, carry_nx;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   acc_upd;
    logic [CW-1:0]      nzcnt_upd;

    always_comb begin
        mk       = m_q[k_q];
        mk1      = m_q[k_q + CW'(1)];
        b        = {1'b0, mk} + {1'b0, carry_q};
        // b==1 gives a nonzero digit; if the next bit is also set it becomes
        // -1 with a carry, which breaks up runs of ones.
        dig_nz   = (b == 2'd1);
        dig_neg  = dig_nz && mk1;
        carry_nx = (b == 2'd2) || dig_neg;
        // A shift of WIDTH or more yields zero, so the top digit adds nothing.
        addend   = x_q << k_q;
        acc_upd  = acc_q;
        nzcnt_upd = nzcnt_q;
        if (dig_nz) begin
            acc_upd   = dig_neg ? (acc_q - addend) : (acc_q + addend);
            nzcnt_upd = nzcnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        m_d         = m_q;
        acc_d       = acc_q;
        k_d         = k_q;
        carry_d     = carry_q;
        nzcnt_d     = nzcnt_q;
        y_d         = y_q;
        nz_d        = nz_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.x;
                    m_d     = {2'b00, bus.multi};
                    acc_d   = '0;
                    k_d     = '0;
                    carry_d = 1'b0;
                    nzcnt_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_upd;
                carry_d = carry_nx;
                nzcnt_d = nzcnt_upd;
                if (k_q == CW'(WIDTH)) begin
                    y_d         = acc_upd;
                    nz_d        = nzcnt_upd;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k_d = k_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            nzcnt_q     <= '0;
            y_q         <= '0;
            nz_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            nzcnt_q     <= nzcnt_d;
            y_q         <= y_d;
            nz_q        <= nz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.nz_digits = nz_q;

endmodule

// File: tb/tb_csd_mult_seq.sv
module tb_csd_mult_seq;

    localparam int WIDTH = 32;
    localparam int CW    = 6;
    localparam int LAT   = WIDTH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csd_mult_seq_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    csd_mult_seq #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain modular product
    function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] m);
        logic [63:0] p;
        p = 64'(a) * 64'(m);
        return p[31:0];
    endfunction

    // Reference: weight of the non-adjacent form, by repeated division
    function automatic int ref_nz(input logic [31:0] m);
        longint n;
        int c;
        n = longint'(m);
        c = 0;
        while (n != 0) begin
            if (n % 2 == 1) begin
                if (n % 4 == 3) n = n + 1;
                else            n = n - 1;
                c++;
            end
            n = n / 2;
        end
        return c;
    endfunction

    task automatic start_op(input logic [31:0] xa, input logic [31:0] ma, output bit to);
        int w;
        w = 0;
        while (!bus.in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        to = !bus.in_ready;
        bus.x = xa;
        bus.multi = ma;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x = $urandom;
        bus.multi = $urandom;
    endtask

    task automatic wait_result(output int lat, output bit to);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !bus.out_valid;
    endtask

    task automatic handshake;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        total++;
        if (bus.y !== 32'd0 || bus.nz_digits !== 6'd0) begin
            bad++; $display("FAIL reset_y_nz got=%h/%0d exp=0/0", bus.y, bus.nz_digits);
        end
    endtask

    task automatic test_directed;
        logic [31:0] xs[5]  = '{32'd5, 32'd1, 32'd3, 32'h80000000, 32'hDEADBEEF};
        logic [31:0] ms[5]  = '{32'd7, 32'hFFFFFFFF, 32'h55555555, 32'd2, 32'd0};
        logic [31:0] ye[5]  = '{32'd35, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        int          nze[5] = '{2, 2, 16, 1, 0};
        bit to;
        int lat;
        for (int i = 0; i < 5; i++) begin
            start_op(xs[i], ms[i], to);
            total++;
            if (to) begin
                bad++; $display("FAIL dir%0d_accept_timeout got=in_ready_low exp=accept", i);
            end
            wait_result(lat, to);
            total++;
            if (to || lat != LAT) begin
                bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT);
            end
            total++;
            if (bus.y !== ye[i]) begin
                bad++; $display("FAIL dir%0d_y got=%h exp=%h", i, bus.y, ye[i]);
            end
            total++;
            if (bus.nz_digits !== CW'(nze[i])) begin
                bad++; $display("FAIL dir%0d_nz got=%0d exp=%0d", i, bus.nz_digits, nze[i]);
            end
            handshake();
        end
    endtask

    task automatic test_stall;
        bit to;
        int lat;
        logic [31:0] xa, ma, yexp;
        xa = $urandom;
        ma = $urandom;
        yexp = ref_y(xa, ma);
        start_op(xa, ma, to);
        wait_result(lat, to);
        total++;
        if (to || bus.y !== yexp) begin
            bad++; $display("FAIL stall_y got=%h exp=%h", bus.y, yexp);
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.x = $urandom;
            bus.multi = $urandom;
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.y !== yexp) begin
                bad++;
                $display("FAIL stall_hold%0d got=ov%b ir%b y%h exp=ov1 ir0 y%h",
                         i, bus.out_valid, bus.in_ready, bus.y, yexp);
            end
        end
        bus.in_valid = 1'b0;
        handshake();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_release got=ov%b ir%b exp=ov0 ir1", bus.out_valid, bus.in_ready);
        end
        start_op(32'd9, 32'd11, to);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL stall_next_accept got=ir%b exp=ir0", bus.in_ready);
        end
        wait_result(lat, to);
        total++;
        if (to || bus.y !== 32'd99 || lat != LAT) begin
            bad++; $display("FAIL stall_next_y got=%0d lat=%0d exp=99 lat=%0d", bus.y, lat, LAT);
        end
        handshake();
    endtask

    task automatic test_reset_mid_run;
        bit to;
        bit seen;
        int lat;
        start_op(32'd123, 32'd456, to);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.y !== 32'd0 || bus.nz_digits !== 6'd0) begin
            bad++;
            $display("FAIL midrst_state got=ir%b ov%b y%h nz%0d exp=ir1 ov0 y0 nz0",
                     bus.in_ready, bus.out_valid, bus.y, bus.nz_digits);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= bus.out_valid;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL midrst_no_result got=out_valid_seen exp=none");
        end
        start_op(32'd5, 32'd7, to);
        wait_result(lat, to);
        total++;
        if (to || bus.y !== 32'd35 || bus.nz_digits !== 6'd2) begin
            bad++; $display("FAIL midrst_after got=%0d/%0d exp=35/2", bus.y, bus.nz_digits);
        end
        handshake();
    endtask

    task automatic test_random;
        bit to;
        int lat;
        logic [31:0] xa, ma, yexp;
        int nexp;
        for (int i = 0; i < 24; i++) begin
            xa = $urandom;
            case (i % 4)
                0: ma = $urandom;
                1: ma = $urandom | ($urandom & $urandom);
                2: ma = $urandom & $urandom & $urandom;
                default: ma = 32'hFFFFFFFF << $urandom_range(0, 31);
            endcase
            yexp = ref_y(xa, ma);
            nexp = ref_nz(ma);
            start_op(xa, ma, to);
            wait_result(lat, to);
            total++;
            if (to || bus.y !== yexp || bus.nz_digits !== CW'(nexp) || lat != LAT) begin
                bad++;
                $display("FAIL rand%0d x=%h m=%h got=%h/%0d lat=%0d exp=%h/%0d lat=%0d",
                         i, xa, ma, bus.y, bus.nz_digits, lat, yexp, nexp, LAT);
            end
            handshake();
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        int lat;
        int prev_acc;
        logic [31:0] xa, ma, yexp;
        bus.out_ready = 1'b1;
        prev_acc = -1;
        for (int i = 0; i < 4; i++) begin
            xa = $urandom;
            ma = $urandom;
            yexp = ref_y(xa, ma);
            start_op(xa, ma, to);
            if (prev_acc >= 0) begin
                total++;
                if (cyc - prev_acc != WIDTH + 3) begin
                    bad++; $display("FAIL b2b_period%0d got=%0d exp=%0d", i, cyc - prev_acc, WIDTH + 3);
                end
            end
            prev_acc = cyc;
            wait_result(lat, to);
            total++;
            if (to || bus.y !== yexp || bus.nz_digits !== CW'(ref_nz(ma))) begin
                bad++; $display("FAIL b2b_y%0d got=%h exp=%h", i, bus.y, yexp);
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain got=ir%b ov%b exp=ir1 ov0", bus.in_ready, bus.out_valid);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.multi     = '0;
        test_reset();
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
